// File: rtl/axi_wr_burst_master.sv
// ---------------------------------------------------------------------------
// axi_wr_burst_master
//   AXI3 write master that streams samples into memory as fixed-length INCR
//   bursts. Issues AW/W, accepts B and forwards every accepted B handshake
//   (valid + resp) to a downstream response counter.
//
// Parameters
//   BURST_LEN  beats per burst (1..16); awlen = BURST_LEN-1
//   DATA_W     data width in bits; awsize = log2(DATA_W/8)
//   MAX_OUTST  max bursts with AW accepted but B not yet received (1..15)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr, n_bursts  transfer request (latched only when idle)
//   din, din_valid, din_ready   sample stream in
//   aw*                         AXI write address channel
//   w*                          AXI write data channel (wdata = din)
//   bvalid, bresp, bready       AXI write response channel
//   resp_valid, resp            accepted B forwarded to response statistics
//   busy, done                  transfer in progress / 1-cycle completion
//   err                         sticky bus-error flag (optional build only)
//
// Optional build
//   AXI_WR_ERR_ABORT_EN: the first B with bresp[1]=1 sets err; no further
//   AWs are issued, already-accepted bursts are finished and drained, then
//   done pulses. Without it, errors are only forwarded on resp/resp_valid.
// ---------------------------------------------------------------------------
module axi_wr_burst_master #(
  parameter int BURST_LEN = 16,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         base_addr,
  input  logic [15:0]         n_bursts,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                resp_valid,
  output logic [1:0]          resp,
  output logic                busy,
  output logic                done
`ifdef AXI_WR_ERR_ABORT_EN
  ,
  output logic                err
`endif
);

  localparam int              BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * (DATA_W / 8));
  localparam logic [3:0]      MAX_OUTST_C = 4'(MAX_OUTST);
  localparam logic [3:0]      AWLEN_C     = 4'(BURST_LEN - 1);
  localparam logic [2:0]      AWSIZE_C    = 3'($clog2(DATA_W / 8));

  // S_ADDR drives awvalid; S_WAIT covers both "outstanding window full" and
  // "all AWs issued, draining W/B".
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                done_nx_s;
  logic                awvalid_r;
  logic                busy_r;
  logic                done_r;
  logic [31:0]         awaddr_r;
  logic [15:0]         n_bursts_r;
  logic [15:0]         aw_cnt_r;
  logic [15:0]         w_burst_cnt_r;
  logic [15:0]         b_cnt_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [3:0]          outst_r;
  logic [3:0]          outst_nx_s;

  logic                start_ok_s;
  logic                aw_hs_s;
  logic                w_win_s;
  logic                w_hs_s;
  logic                b_hs_s;
  logic                aw_last_s;
  logic                all_aw_s;
  logic                b_last_s;
  logic                abort_s;

  assign start_ok_s = start && (state_r == S_IDLE);
  assign aw_hs_s    = awvalid_r && awready;
  // W may only run for bursts whose AW has already been accepted.
  assign w_win_s    = busy_r && (w_burst_cnt_r < aw_cnt_r);
  assign w_hs_s     = w_win_s && din_valid && wready;
  assign b_hs_s     = busy_r && bvalid;
  assign aw_last_s  = ((aw_cnt_r + 16'd1) == n_bursts_r);
  assign all_aw_s   = (aw_cnt_r == n_bursts_r);
  // This B is the last one owed for every AW issued so far.
  assign b_last_s   = b_hs_s && ((b_cnt_r + 16'd1) == aw_cnt_r);

`ifdef AXI_WR_ERR_ABORT_EN
  logic err_r;
  // An error B in the current cycle already blocks new AWs.
  assign abort_s = err_r || (b_hs_s && bresp[1]);
  assign err     = err_r;
`else
  assign abort_s = 1'b0;
`endif

  // Outstanding-burst count after this cycle's AW and B handshakes.
  always_comb begin
    outst_nx_s = outst_r;
    case ({aw_hs_s, b_hs_s})
      2'b10:   outst_nx_s = outst_r + 4'd1;
      2'b01:   outst_nx_s = outst_r - 4'd1;
      default: outst_nx_s = outst_r;
    endcase
  end

  // AW/transfer FSM next-state and done decode.
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (n_bursts != 16'd0) begin
            state_nx_s = S_ADDR;
          end else begin
            done_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ADDR: begin
        // awvalid is held until accepted; decide afterwards whether to go on.
        if (aw_hs_s) begin
          if (aw_last_s || abort_s || (outst_nx_s == MAX_OUTST_C)) begin
            state_nx_s = S_WAIT;
          end else begin
            state_nx_s = S_ADDR;
          end
        end else begin
          state_nx_s = S_ADDR;
        end
      end
      S_WAIT: begin
        if (b_last_s && (all_aw_s || abort_s)) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else if (!all_aw_s && !abort_s && (outst_nx_s < MAX_OUTST_C)) begin
          state_nx_s = S_ADDR;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM state plus registered awvalid/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      awvalid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      awvalid_r <= (state_nx_s == S_ADDR);
      busy_r    <= (state_nx_s != S_IDLE);
      done_r    <= done_nx_s;
    end
  end

  // Address, burst/beat counters and outstanding tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_r      <= 32'd0;
      n_bursts_r    <= 16'd0;
      aw_cnt_r      <= 16'd0;
      w_burst_cnt_r <= 16'd0;
      b_cnt_r       <= 16'd0;
      beat_cnt_r    <= {BEAT_W{1'b0}};
      outst_r       <= 4'd0;
    end else if (start_ok_s) begin
      awaddr_r      <= base_addr;
      n_bursts_r    <= n_bursts;
      aw_cnt_r      <= 16'd0;
      w_burst_cnt_r <= 16'd0;
      b_cnt_r       <= 16'd0;
      beat_cnt_r    <= {BEAT_W{1'b0}};
      outst_r       <= 4'd0;
    end else begin
      if (aw_hs_s) begin
        awaddr_r <= awaddr_r + BURST_BYTES;
        aw_cnt_r <= aw_cnt_r + 16'd1;
      end else begin
        awaddr_r <= awaddr_r;
        aw_cnt_r <= aw_cnt_r;
      end
      if (w_hs_s) begin
        if (beat_cnt_r == LAST_BEAT) begin
          beat_cnt_r    <= {BEAT_W{1'b0}};
          w_burst_cnt_r <= w_burst_cnt_r + 16'd1;
        end else begin
          beat_cnt_r    <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          w_burst_cnt_r <= w_burst_cnt_r;
        end
      end else begin
        beat_cnt_r    <= beat_cnt_r;
        w_burst_cnt_r <= w_burst_cnt_r;
      end
      if (b_hs_s) begin
        b_cnt_r <= b_cnt_r + 16'd1;
      end else begin
        b_cnt_r <= b_cnt_r;
      end
      outst_r <= outst_nx_s;
    end
  end

`ifdef AXI_WR_ERR_ABORT_EN
  // Sticky error flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (b_hs_s && bresp[1]) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`endif

  assign awaddr     = awaddr_r;
  assign awlen      = AWLEN_C;
  assign awsize     = AWSIZE_C;
  assign awburst    = 2'b01;
  assign awvalid    = awvalid_r;
  assign wdata      = din;
  assign wstrb      = {(DATA_W/8){1'b1}};
  assign wlast      = w_win_s && (beat_cnt_r == LAST_BEAT);
  assign wvalid     = w_win_s && din_valid;
  assign din_ready  = w_win_s && wready;
  assign bready     = busy_r;
  assign resp_valid = bvalid && busy_r;
  assign resp       = bresp;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
